// File: rtl/cache_miss_arbiter_pkg.sv
// Shared types and constants for the cache miss arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_miss_arbiter_pkg;

  localparam int BLOCK_OFFSET_BITS = 5;
  localparam int BLOCK_BYTES       = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RESPOND = 3'd4
  } arb_state_t;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } arb_src_t;

endpackage

// File: rtl/cache_miss_arbiter_rr_arbiter2.sv
// Two-way round-robin picker between the icache and dcache request sources.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller only samples the grant when it can act on it.
// Ports: i_req_ic/i_req_dc raw requests, i_last_grant previous winner,
//        i_mask_vld/i_mask_src exclude one side for a cycle, o_gnt_vld/o_gnt_src result.
module rr_arbiter2
  import cache_miss_arbiter_pkg::*;
(
  input  logic     i_req_ic,
  input  logic     i_req_dc,
  input  arb_src_t i_last_grant,
  input  logic     i_mask_vld,
  input  arb_src_t i_mask_src,
  output logic     o_gnt_vld,
  output arb_src_t o_gnt_src
);

  logic w_ic_elig;
  logic w_dc_elig;

  // The side served last turn may still show a stale request for one cycle.
  assign w_ic_elig = i_req_ic & ~(i_mask_vld & (i_mask_src == SRC_IC));
  assign w_dc_elig = i_req_dc & ~(i_mask_vld & (i_mask_src == SRC_DC));

  always_comb begin
    o_gnt_vld = w_ic_elig | w_dc_elig;
    o_gnt_src = SRC_IC;
    if (w_ic_elig && w_dc_elig) begin
      // Tie: the side that did not win last time goes now.
      o_gnt_src = (i_last_grant == SRC_IC) ? SRC_DC : SRC_IC;
    end else if (w_dc_elig) begin
      o_gnt_src = SRC_DC;
    end
  end

endmodule

// File: rtl/cache_miss_arbiter.sv
// Serialises icache/dcache miss repairs and dcache writebacks onto one block memory port.
// Latency: read repair resolves 3 cycles after the request is seen in IDLE (zero-wait memory).
// Backpressure: mem_req_* held stable until mem_req_ready; requests wait as level signals.
// Ports: ic_*/dc_* repair request + response per cache, dc_wb_* writeback handshake,
//        mem_req_*/mem_resp_* single outstanding block transaction to memory.
module cache_miss_arbiter
  import cache_miss_arbiter_pkg::*;
#(
  parameter int BLOCK_BITS = 256,
  parameter int ADDR_BITS  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ic_read_miss_repair,
  input  logic [ADDR_BITS-1:0]    ic_missed_addr,
  output logic                    ic_waddr_valid,
  output logic [ADDR_BITS-1:0]    ic_waddr,
  output logic [BLOCK_BITS-1:0]   ic_wdata,
  output logic [BLOCK_BITS/8-1:0] ic_wmask,
  output logic                    ic_repair_resolved,
  input  logic                    dc_read_miss_repair,
  input  logic [ADDR_BITS-1:0]    dc_missed_addr,
  output logic                    dc_waddr_valid,
  output logic [ADDR_BITS-1:0]    dc_waddr,
  output logic [BLOCK_BITS-1:0]   dc_wdata,
  output logic [BLOCK_BITS/8-1:0] dc_wmask,
  output logic                    dc_repair_resolved,
  input  logic                    dc_wb_valid,
  input  logic [ADDR_BITS-1:0]    dc_wb_addr,
  input  logic [BLOCK_BITS-1:0]   dc_wb_data,
  output logic                    dc_wb_done,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_BITS-1:0]    mem_req_addr,
  output logic [BLOCK_BITS-1:0]   mem_req_wdata,
  input  logic                    mem_resp_valid,
  input  logic [BLOCK_BITS-1:0]   mem_resp_rdata
);

  localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
    ~((ADDR_BITS'(1) << BLOCK_OFFSET_BITS) - ADDR_BITS'(1));

  arb_state_t            r_state;
  arb_src_t              r_grant;
  arb_src_t              r_last_grant;
  logic                  r_mask_vld;
  arb_src_t              r_mask_src;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [BLOCK_BITS-1:0] r_rdata;

  logic                  w_gnt_vld;
  arb_src_t              w_gnt_src;
  logic [ADDR_BITS-1:0]  w_ic_addr_al;
  logic [ADDR_BITS-1:0]  w_dc_addr_al;
  logic [ADDR_BITS-1:0]  w_wb_addr_al;
  logic                  w_respond;

  assign w_ic_addr_al = ic_missed_addr & ALIGN_MASK;
  assign w_dc_addr_al = dc_missed_addr & ALIGN_MASK;
  assign w_wb_addr_al = dc_wb_addr & ALIGN_MASK;

  rr_arbiter2 u_rr (
    .i_req_ic     (ic_read_miss_repair),
    .i_req_dc     (dc_read_miss_repair | dc_wb_valid),
    .i_last_grant (r_last_grant),
    .i_mask_vld   (r_mask_vld),
    .i_mask_src   (r_mask_src),
    .o_gnt_vld    (w_gnt_vld),
    .o_gnt_src    (w_gnt_src)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= SRC_IC;
      r_last_grant <= SRC_IC;
      r_mask_vld   <= 1'b0;
      r_mask_src   <= SRC_IC;
      r_addr       <= '0;
      r_rdata      <= '0;
    end else begin
      // Mask lives for exactly the first IDLE cycle after a completed turn.
      r_mask_vld <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_grant      <= w_gnt_src;
            r_last_grant <= w_gnt_src;
            if (w_gnt_src == SRC_DC) begin
              r_addr  <= w_dc_addr_al;
              r_state <= dc_wb_valid ? ST_WB_REQ : ST_RD_REQ;
            end else begin
              r_addr  <= w_ic_addr_al;
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_WB_REQ: begin
          if (mem_req_ready) begin
            if (dc_read_miss_repair) begin
              // The read may have been raised while the writeback waited; relatch it.
              r_addr  <= w_dc_addr_al;
              r_state <= ST_RD_REQ;
            end else begin
              r_state    <= ST_IDLE;
              r_mask_vld <= 1'b1;
              r_mask_src <= SRC_DC;
            end
          end
        end
        ST_RD_REQ: begin
          if (mem_req_ready) r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (mem_resp_valid) begin
            r_rdata <= mem_resp_rdata;
            r_state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          r_state    <= ST_IDLE;
          r_mask_vld <= 1'b1;
          r_mask_src <= r_grant;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_respond = (r_state == ST_RESPOND);

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    dc_wb_done    = 1'b0;
    if (r_state == ST_WB_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b1;
      mem_req_addr  = w_wb_addr_al;
      mem_req_wdata = dc_wb_data;
      dc_wb_done    = mem_req_ready;
    end else if (r_state == ST_RD_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = r_addr;
    end
  end

  always_comb begin
    ic_waddr_valid     = 1'b0;
    ic_repair_resolved = 1'b0;
    ic_waddr           = '0;
    ic_wdata           = '0;
    ic_wmask           = '0;
    dc_waddr_valid     = 1'b0;
    dc_repair_resolved = 1'b0;
    dc_waddr           = '0;
    dc_wdata           = '0;
    dc_wmask           = '0;
    if (w_respond && (r_grant == SRC_IC)) begin
      ic_waddr_valid     = 1'b1;
      ic_repair_resolved = 1'b1;
      ic_waddr           = r_addr;
      ic_wdata           = r_rdata;
      ic_wmask           = '1;
    end
    if (w_respond && (r_grant == SRC_DC)) begin
      dc_waddr_valid     = 1'b1;
      dc_repair_resolved = 1'b1;
      dc_waddr           = r_addr;
      dc_wdata           = r_rdata;
      dc_wmask           = '1;
    end
  end

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// Directed bench for cache_miss_arbiter with a hand-driven memory port.
// Latency: checks the 3-cycle minimum repair path cycle by cycle.
// Backpressure: exercises mem_req_ready low stalls and reset during RD_WAIT.
module tb_cache_miss_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_read_miss_repair, dc_read_miss_repair;
  logic [31:0]  ic_missed_addr, dc_missed_addr;
  logic         ic_waddr_valid, dc_waddr_valid;
  logic [31:0]  ic_waddr, dc_waddr;
  logic [255:0] ic_wdata, dc_wdata;
  logic [31:0]  ic_wmask, dc_wmask;
  logic         ic_repair_resolved, dc_repair_resolved;
  logic         dc_wb_valid;
  logic [31:0]  dc_wb_addr;
  logic [255:0] dc_wb_data;
  logic         dc_wb_done;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [255:0] mem_req_wdata;
  logic         mem_resp_valid;
  logic [255:0] mem_resp_rdata;

  int checks = 0;
  int errors = 0;

  logic [255:0] blk_a = {32'h0000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                         32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777};
  logic [255:0] blk_b = {8{32'hDEAD_BEEF}};

  always #5 clk = ~clk;

  cache_miss_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_read_miss_repair(ic_read_miss_repair), .ic_missed_addr(ic_missed_addr),
    .ic_waddr_valid(ic_waddr_valid), .ic_waddr(ic_waddr), .ic_wdata(ic_wdata),
    .ic_wmask(ic_wmask), .ic_repair_resolved(ic_repair_resolved),
    .dc_read_miss_repair(dc_read_miss_repair), .dc_missed_addr(dc_missed_addr),
    .dc_waddr_valid(dc_waddr_valid), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata),
    .dc_wmask(dc_wmask), .dc_repair_resolved(dc_repair_resolved),
    .dc_wb_valid(dc_wb_valid), .dc_wb_addr(dc_wb_addr), .dc_wb_data(dc_wb_data),
    .dc_wb_done(dc_wb_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory side of one transaction: waits (bounded) for a request, accepts it,
  // and for reads returns data on the next cycle. Returns in the RESPOND cycle for reads.
  task automatic mem_serve(input logic [255:0] data, output logic [31:0] addr,
                           output logic we, output logic [255:0] wdat, output logic wbd,
                           output logic ic_rr, output logic dc_rr, output bit ok);
    ok = 1'b0; addr = '0; we = 1'b0; wdat = '0; wbd = 1'b0; ic_rr = 1'b0; dc_rr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) return;
    addr = mem_req_addr; we = mem_req_we; wdat = mem_req_wdata; wbd = dc_wb_done;
    tick();
    if (!we) begin
      mem_resp_valid = 1'b1; mem_resp_rdata = data;
      tick();
      mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      ic_rr = ic_repair_resolved; dc_rr = dc_repair_resolved;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_we, dc_wb_done, ic_waddr_valid, ic_repair_resolved,
         dc_waddr_valid, dc_repair_resolved} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0", {mem_req_valid, mem_req_we,
        dc_wb_done, ic_waddr_valid, ic_repair_resolved, dc_waddr_valid, dc_repair_resolved});
    end
    checks++;
    if ({mem_req_addr, ic_waddr, dc_waddr, ic_wmask, dc_wmask} !== 160'b0) begin
      errors++; $display("FAIL reset_addr_mask: got nonzero addr/mask, expected 0");
    end
    checks++;
    if ({mem_req_wdata, ic_wdata, dc_wdata} !== 768'b0) begin
      errors++; $display("FAIL reset_data: got nonzero data, expected 0");
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dc_read();
    dc_read_miss_repair = 1'b1; dc_missed_addr = 32'hAABB_CCDD;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL dcrd_c0_valid: got %b expected 0", mem_req_valid);
    end
    tick();
    checks++;
    if ({mem_req_valid, mem_req_we, mem_req_addr} !== {1'b1, 1'b0, 32'hAABB_CCC0}) begin
      errors++; $display("FAIL dcrd_c1_req: got v=%b we=%b a=%h expected v=1 we=0 a=aabbccc0",
                         mem_req_valid, mem_req_we, mem_req_addr);
    end
    tick();
    checks++;
    if ({mem_req_valid, dc_repair_resolved} !== 2'b00) begin
      errors++; $display("FAIL dcrd_c2_wait: got v=%b rr=%b expected 0 0",
                         mem_req_valid, dc_repair_resolved);
    end
    mem_resp_valid = 1'b1; mem_resp_rdata = blk_a;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    checks++;
    if ({dc_repair_resolved, dc_waddr_valid, dc_waddr, dc_wmask} !==
        {1'b1, 1'b1, 32'hAABB_CCC0, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL dcrd_c3_resp: got rr=%b wv=%b a=%h m=%h expected 1 1 aabbccc0 ffffffff",
                         dc_repair_resolved, dc_waddr_valid, dc_waddr, dc_wmask);
    end
    checks++;
    if (dc_wdata !== blk_a) begin
      errors++; $display("FAIL dcrd_c3_data: got %h expected %h", dc_wdata, blk_a);
    end
    checks++;
    if ({ic_waddr_valid, ic_repair_resolved, ic_waddr, ic_wdata, ic_wmask} !== 322'b0) begin
      errors++; $display("FAIL dcrd_ic_quiet: got nonzero ic outputs, expected 0");
    end
    dc_read_miss_repair = 1'b0;
    tick();
    checks++;
    if ({dc_repair_resolved, dc_waddr_valid} !== 2'b00) begin
      errors++; $display("FAIL dcrd_c4_pulse: got rr=%b wv=%b expected 0 0",
                         dc_repair_resolved, dc_waddr_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] a; logic we, wbd, icr, dcr; logic [255:0] wd; bit ok;
    rst = 1'b1; #1; @(negedge clk); rst = 1'b0; tick();
    ic_read_miss_repair = 1'b1; ic_missed_addr = 32'h0000_0100;
    dc_read_miss_repair = 1'b1; dc_missed_addr = 32'h0000_0200;
    mem_serve(blk_b, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, icr, dcr} !== {1'b1, 32'h0000_0200, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rr_tie1_first: got ok=%b a=%h ic=%b dc=%b expected 1 00000200 0 1",
                         ok, a, icr, dcr);
    end
    dc_read_miss_repair = 1'b0;
    mem_serve(blk_b, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, icr, dcr} !== {1'b1, 32'h0000_0100, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rr_tie1_second: got ok=%b a=%h ic=%b dc=%b expected 1 00000100 1 0",
                         ok, a, icr, dcr);
    end
    ic_read_miss_repair = 1'b0;
    tick(); tick();
    dc_read_miss_repair = 1'b1; dc_missed_addr = 32'h0000_0300;
    mem_serve(blk_b, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, dcr} !== {1'b1, 32'h0000_0300, 1'b1}) begin
      errors++; $display("FAIL rr_lone_dc: got ok=%b a=%h dc=%b expected 1 00000300 1", ok, a, dcr);
    end
    dc_read_miss_repair = 1'b0;
    tick(); tick();
    ic_read_miss_repair = 1'b1; ic_missed_addr = 32'h0000_0400;
    dc_read_miss_repair = 1'b1; dc_missed_addr = 32'h0000_0500;
    mem_serve(blk_b, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, icr, dcr} !== {1'b1, 32'h0000_0400, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rr_tie2_first: got ok=%b a=%h ic=%b dc=%b expected 1 00000400 1 0",
                         ok, a, icr, dcr);
    end
    ic_read_miss_repair = 1'b0;
    mem_serve(blk_b, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, icr, dcr} !== {1'b1, 32'h0000_0500, 1'b0, 1'b1}) begin
      errors++; $display("FAIL rr_tie2_second: got ok=%b a=%h ic=%b dc=%b expected 1 00000500 0 1",
                         ok, a, icr, dcr);
    end
    dc_read_miss_repair = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wb_then_read();
    logic [31:0] a; logic we, wbd, icr, dcr; logic [255:0] wd; bit ok;
    dc_wb_valid = 1'b1; dc_wb_addr = 32'h0000_1040; dc_wb_data = {64{4'h5}};
    dc_read_miss_repair = 1'b1; dc_missed_addr = 32'h0000_2000;
    mem_serve(blk_a, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, we, wbd, a} !== {1'b1, 1'b1, 1'b1, 32'h0000_1040}) begin
      errors++; $display("FAIL wb_write: got ok=%b we=%b done=%b a=%h expected 1 1 1 00001040",
                         ok, we, wbd, a);
    end
    checks++;
    if (wd !== {64{4'h5}}) begin
      errors++; $display("FAIL wb_wdata: got %h expected all 5", wd);
    end
    dc_wb_valid = 1'b0;
    checks++;
    if (dc_wb_done !== 1'b0) begin
      errors++; $display("FAIL wb_done_pulse: got %b expected 0", dc_wb_done);
    end
    mem_serve(blk_a, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, we, a, dcr} !== {1'b1, 1'b0, 32'h0000_2000, 1'b1}) begin
      errors++; $display("FAIL wb_then_read: got ok=%b we=%b a=%h dc=%b expected 1 0 00002000 1",
                         ok, we, a, dcr);
    end
    checks++;
    if (dc_wdata !== blk_a) begin
      errors++; $display("FAIL wb_read_data: got %h expected %h", dc_wdata, blk_a);
    end
    dc_read_miss_repair = 1'b0;
    tick(); tick();
  endtask

  task automatic test_stall();
    logic [31:0] a; logic we, wbd, icr, dcr; logic [255:0] wd; bit ok;
    mem_req_ready = 1'b0;
    ic_read_miss_repair = 1'b1; ic_missed_addr = 32'h0000_3017;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_req_seen: got no request expected mem_req_valid=1");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req_valid, mem_req_we, mem_req_addr} !== {1'b1, 1'b0, 32'h0000_3000}) begin
        errors++; $display("FAIL stall_hold_%0d: got v=%b we=%b a=%h expected 1 0 00003000",
                           i, mem_req_valid, mem_req_we, mem_req_addr);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    mem_serve(blk_b, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, icr} !== {1'b1, 32'h0000_3000, 1'b1}) begin
      errors++; $display("FAIL stall_complete: got ok=%b a=%h ic=%b expected 1 00003000 1", ok, a, icr);
    end
    ic_read_miss_repair = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; logic we, wbd, icr, dcr; logic [255:0] wd; bit ok;
    ic_read_miss_repair = 1'b1; ic_missed_addr = 32'h0000_4000;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) break;
      tick();
    end
    tick();
    #1 rst = 1'b1; ic_read_miss_repair = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, ic_repair_resolved, ic_waddr_valid, mem_req_addr} !== 35'b0) begin
      errors++; $display("FAIL rstmid_outputs: got v=%b rr=%b wv=%b a=%h expected all 0",
                         mem_req_valid, ic_repair_resolved, ic_waddr_valid, mem_req_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_resp_rdata = blk_a;
    tick();
    mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mem_req_valid, ic_repair_resolved, dc_repair_resolved} !== 3'b000) begin
        errors++; $display("FAIL rstmid_ignored_%0d: got v=%b icr=%b dcr=%b expected 0 0 0",
                           i, mem_req_valid, ic_repair_resolved, dc_repair_resolved);
      end
      tick();
    end
    ic_read_miss_repair = 1'b1; ic_missed_addr = 32'h0000_5000;
    mem_serve(blk_b, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, icr, ic_wdata} !== {1'b1, 32'h0000_5000, 1'b1, blk_b}) begin
      errors++; $display("FAIL rstmid_next_ic: got ok=%b a=%h ic=%b expected 1 00005000 1 with data",
                         ok, a, icr);
    end
    ic_read_miss_repair = 1'b0;
    tick(); tick();
  endtask

  task automatic test_hold_extra();
    logic [31:0] a; logic we, wbd, icr, dcr; logic [255:0] wd; bit ok;
    int extra_reqs;
    ic_read_miss_repair = 1'b1; ic_missed_addr = 32'h0000_6000;
    mem_serve(blk_a, a, we, wd, wbd, icr, dcr, ok);
    checks++;
    if ({ok, a, icr} !== {1'b1, 32'h0000_6000, 1'b1}) begin
      errors++; $display("FAIL hold_first: got ok=%b a=%h ic=%b expected 1 00006000 1", ok, a, icr);
    end
    tick();
    ic_read_miss_repair = 1'b0;
    extra_reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req_valid) extra_reqs++;
      tick();
    end
    checks++;
    if (extra_reqs !== 0) begin
      errors++; $display("FAIL hold_no_dup: got %0d request cycles expected 0", extra_reqs);
    end
  endtask

  initial begin
    rst = 1'b1;
    ic_read_miss_repair = 1'b0; ic_missed_addr = '0;
    dc_read_miss_repair = 1'b0; dc_missed_addr = '0;
    dc_wb_valid = 1'b0; dc_wb_addr = '0; dc_wb_data = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    #12;
    test_reset();
    test_dc_read();
    test_round_robin();
    test_wb_then_read();
    test_stall();
    test_reset_mid();
    test_hold_extra();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
